// File: rtl/cpu4_pkg.sv
// Shared write-back types and constants: register file geometry, load funct3 codes and the buffered-write entry.
package cpu4_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_ent_t;
endpackage

// File: rtl/cpu4_wb_ldfmt.sv
// Load formatter: picks the byte/half from the aligned word and extends it; purely combinational, no flow control.
module cpu4_wb_ldfmt
  import cpu4_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'(raw >> {addr_lo, 3'b000});
    h = addr_lo[1] ? raw[31:16] : raw[15:0];
    case (funct3)
      F3_LB:   data = {{(XLEN-8){b[7]}}, b};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, b};
      F3_LH:   data = {{(XLEN-16){h[15]}}, h};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, h};
      default: data = raw;
    endcase
  end
endmodule

// File: rtl/cpu4_wb.sv
// Write-back arbiter: load > buffered ALU > bypassed ALU, one registered regfile write per cycle (1-cycle latency); optional CPU4_WB_FWD_EN forwards the write to rs1/rs2.
// Backpressure: alu_ready drops while the ALU buffer is full (even if it pops that cycle); loads are never stalled.
module cpu4_wb
  import cpu4_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 ld_valid,
  input  logic [REG_IDX_W-1:0] ld_rd,
  input  logic [2:0]           ld_funct3,
  input  logic [1:0]           ld_addr_lo,
  input  logic [XLEN-1:0]      ld_data,
  output logic                 wen,
  output logic [REG_IDX_W-1:0] rdidx,
  output logic [XLEN-1:0]      rddata,
  input  logic [REG_IDX_W-1:0] rs1idx,
  input  logic [REG_IDX_W-1:0] rs2idx,
  input  logic [XLEN-1:0]      rs1data_rf,
  input  logic [XLEN-1:0]      rs2data_rf,
  output logic [XLEN-1:0]      rs1data,
  output logic [XLEN-1:0]      rs2data,
  output logic                 busy
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  wb_ent_t         mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            out_of_reset;
  logic [XLEN-1:0] ld_fmt;
  wb_ent_t         head, sel;
  logic            sel_vld, push, pop, alu_acc, fifo_empty;

  cpu4_wb_ldfmt u_ldfmt (
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .raw     (ld_data),
    .data    (ld_fmt)
  );

  assign fifo_empty = (count == '0);
  assign alu_ready  = out_of_reset && (count != CW'(FIFO_DEPTH));
  assign alu_acc    = alu_valid && alu_ready;
  assign head       = mem[rd_ptr];
  assign busy       = wen || !fifo_empty;

  // An accepted ALU result that loses arbitration is buffered, never dropped.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    if (ld_valid) begin
      sel_vld   = 1'b1;
      sel.rd    = ld_rd;
      sel.data  = ld_fmt;
      push      = alu_acc;
    end else if (!fifo_empty) begin
      sel_vld = 1'b1;
      sel     = head;
      pop     = 1'b1;
      push    = alu_acc;
    end else if (alu_acc) begin
      sel_vld  = 1'b1;
      sel.rd   = alu_rd;
      sel.data = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: alu_rd, data: alu_data};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_of_reset <= 1'b0;
      wen          <= 1'b0;
      rdidx        <= '0;
      rddata       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      out_of_reset <= 1'b1;
      wen          <= sel_vld && (sel.rd != '0);
      if (sel_vld) begin
        rdidx  <= sel.rd;
        rddata <= sel.data;
      end
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

`ifdef CPU4_WB_FWD_EN
  assign rs1data = (wen && rdidx == rs1idx && rs1idx != '0) ? rddata : rs1data_rf;
  assign rs2data = (wen && rdidx == rs2idx && rs2idx != '0) ? rddata : rs2data_rf;
`else
  logic unused_rs_idx;
  assign unused_rs_idx = ^{rs1idx, rs2idx};
  assign rs1data = rs1data_rf;
  assign rs2data = rs2data_rf;
`endif
endmodule

// File: tb/tb_cpu4_wb.sv
// Directed bench for cpu4_wb: reset, bypass, load priority, buffer fill/drain, load formatting, x0 writes, forwarding and mid-run reset.
module tb_cpu4_wb;
  logic        clk, resetn;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_data;
  logic        wen;
  logic [4:0]  rdidx;
  logic [31:0] rddata;
  logic [4:0]  rs1idx, rs2idx;
  logic [31:0] rs1data_rf, rs2data_rf, rs1data, rs2data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  cpu4_wb #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .ld_data(ld_data),
    .wen(wen), .rdidx(rdidx), .rddata(rddata),
    .rs1idx(rs1idx), .rs2idx(rs2idx), .rs1data_rf(rs1data_rf), .rs2data_rf(rs2data_rf),
    .rs1data(rs1data), .rs2data(rs2data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_funct3 = 3'b010; ld_addr_lo = '0; ld_data = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    rs1idx = '0; rs2idx = '0; rs1data_rf = '0; rs2data_rf = '0;
    #3;
    total++; if (wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", wen); end
    total++; if (rdidx !== 5'd0) begin bad++; $display("FAIL reset_rdidx got=%0d exp=0", rdidx); end
    total++; if (rddata !== 32'h0) begin bad++; $display("FAIL reset_rddata got=%h exp=0", rddata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL reset_alu_ready got=%b exp=0", alu_ready); end
    step();
    step();
    @(negedge clk);
    resetn = 1'b1;
    step();
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_rise got=%b exp=1", alu_ready); end
  endtask

  task automatic test_alu_bypass();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11223344;
    step();
    alu_valid = 1'b0;
    total++; if (wen !== 1'b1) begin bad++; $display("FAIL bypass_wen got=%b exp=1", wen); end
    total++; if (rdidx !== 5'd3) begin bad++; $display("FAIL bypass_rdidx got=%0d exp=3", rdidx); end
    total++; if (rddata !== 32'h11223344) begin bad++; $display("FAIL bypass_rddata got=%h exp=11223344", rddata); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bypass_busy got=%b exp=1", busy); end
    step();
    total++; if (wen !== 1'b0) begin bad++; $display("FAIL bypass_idle_wen got=%b exp=0", wen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bypass_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_ld_priority();
    ld_valid = 1'b1; ld_rd = 5'd5; ld_funct3 = 3'b010; ld_data = 32'hCAFEF00D;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66666666;
    step();
    idle();
    total++; if (wen !== 1'b1 || rdidx !== 5'd5) begin bad++; $display("FAIL prio_load got=wen%b/x%0d exp=wen1/x5", wen, rdidx); end
    total++; if (rddata !== 32'hCAFEF00D) begin bad++; $display("FAIL prio_load_data got=%h exp=cafef00d", rddata); end
    step();
    total++; if (wen !== 1'b1 || rdidx !== 5'd6) begin bad++; $display("FAIL prio_alu got=wen%b/x%0d exp=wen1/x6", wen, rdidx); end
    total++; if (rddata !== 32'h66666666) begin bad++; $display("FAIL prio_alu_data got=%h exp=66666666", rddata); end
    step();
    total++; if (wen !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL prio_drained got=wen%b/busy%b exp=0/0", wen, busy); end
  endtask

  task automatic test_fifo_fill();
    ld_valid = 1'b1; ld_funct3 = 3'b010;
    ld_rd = 5'd20; ld_data = 32'h20202020;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0A0A0A0;
    step();
    total++; if (rdidx !== 5'd20 || rddata !== 32'h20202020) begin bad++; $display("FAIL fill_ld1 got=x%0d/%h exp=x20/20202020", rdidx, rddata); end
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL fill_ready1 got=%b exp=1", alu_ready); end
    ld_rd = 5'd21; ld_data = 32'h21212121;
    alu_rd = 5'd11; alu_data = 32'hB0B0B0B0;
    step();
    total++; if (rdidx !== 5'd21 || wen !== 1'b1) begin bad++; $display("FAIL fill_ld2 got=x%0d/wen%b exp=x21/wen1", rdidx, wen); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", alu_ready); end
    ld_rd = 5'd22; ld_data = 32'h22222222;
    alu_rd = 5'd12; alu_data = 32'hC0C0C0C0;
    step();
    total++; if (rdidx !== 5'd22 || rddata !== 32'h22222222) begin bad++; $display("FAIL fill_ld3 got=x%0d/%h exp=x22/22222222", rdidx, rddata); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL fill_still_full got=%b exp=0", alu_ready); end
    ld_valid = 1'b0;
    step();
    total++; if (wen !== 1'b1 || rdidx !== 5'd10 || rddata !== 32'hA0A0A0A0) begin bad++; $display("FAIL drain1 got=wen%b/x%0d/%h exp=wen1/x10/a0a0a0a0", wen, rdidx, rddata); end
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL drain1_ready got=%b exp=1", alu_ready); end
    step();
    alu_valid = 1'b0;
    total++; if (rdidx !== 5'd11 || rddata !== 32'hB0B0B0B0) begin bad++; $display("FAIL drain2 got=x%0d/%h exp=x11/b0b0b0b0", rdidx, rddata); end
    step();
    total++; if (wen !== 1'b1 || rdidx !== 5'd12 || rddata !== 32'hC0C0C0C0) begin bad++; $display("FAIL drain3 got=wen%b/x%0d/%h exp=wen1/x12/c0c0c0c0", wen, rdidx, rddata); end
    step();
    total++; if (wen !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL drain_empty got=wen%b/busy%b exp=0/0", wen, busy); end
    idle();
  endtask

  task automatic test_ldfmt();
    logic [2:0]  f3  [8] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b000, 3'b011};
    logic [1:0]  off [8] = '{2'd0,   2'd2,   2'd3,   2'd2,   2'd0,   2'd0,   2'd1,   2'd0};
    logic [31:0] exp [8] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF,
                             32'h00007F01, 32'h00007F01, 32'h0000007F, 32'h80FF7F01};
    ld_data = 32'h80FF7F01; ld_rd = 5'd7;
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1; ld_funct3 = f3[i]; ld_addr_lo = off[i];
      step();
      total++; if (wen !== 1'b1 || rddata !== exp[i]) begin bad++; $display("FAIL ldfmt_%0d got=wen%b/%h exp=wen1/%h", i, wen, rddata, exp[i]); end
    end
    idle();
    step();
  endtask

  task automatic test_rd_zero_fwd();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    total++; if (wen !== 1'b0) begin bad++; $display("FAIL alu_x0_wen got=%b exp=0", wen); end
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h12121212;
    step();
    ld_valid = 1'b0;
    total++; if (wen !== 1'b0) begin bad++; $display("FAIL ld_x0_wen got=%b exp=0", wen); end
    rs1idx = 5'd1; rs1data_rf = 32'h12345678;
    rs2idx = 5'd2; rs2data_rf = 32'h55555555;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hAABBCCDD;
    step();
    alu_valid = 1'b0;
    total++; if (wen !== 1'b1 || rdidx !== 5'd1) begin bad++; $display("FAIL fwd_wen got=wen%b/x%0d exp=wen1/x1", wen, rdidx); end
`ifdef CPU4_WB_FWD_EN
    total++; if (rs1data !== 32'hAABBCCDD) begin bad++; $display("FAIL fwd_rs1 got=%h exp=aabbccdd", rs1data); end
`else
    total++; if (rs1data !== 32'h12345678) begin bad++; $display("FAIL pass_rs1 got=%h exp=12345678", rs1data); end
`endif
    total++; if (rs2data !== 32'h55555555) begin bad++; $display("FAIL rs2_no_fwd got=%h exp=55555555", rs2data); end
    step();
    total++; if (rs1data !== 32'h12345678) begin bad++; $display("FAIL rs1_after got=%h exp=12345678", rs1data); end
    rs1idx = '0; rs2idx = '0;
  endtask

  task automatic test_reset_mid();
    ld_valid = 1'b1; ld_rd = 5'd20; ld_funct3 = 3'b010; ld_data = 32'h44444444;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h08080808;
    step();
    alu_rd = 5'd9; alu_data = 32'h09090909;
    step();
    idle();
    total++; if (alu_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL mid_full got=ready%b/busy%b exp=0/1", alu_ready, busy); end
    #2 resetn = 1'b0;
    #1;
    total++; if (wen !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_reset got=wen%b/busy%b exp=0/0", wen, busy); end
    total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got=%b exp=0", alu_ready); end
    step();
    #2 resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (wen !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stale_%0d got=wen%b/busy%b exp=0/0", i, wen, busy); end
    end
    total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_back got=%b exp=1", alu_ready); end
  endtask

  initial begin
    test_reset();
    test_alu_bypass();
    test_ld_priority();
    test_fifo_fill();
    test_ldfmt();
    test_rd_zero_fwd();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu4_wb.md
CPU4_WB -- requirements
Module: cpu4_wb

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: depth of the ALU-result buffer.
REQ-002 The block SHALL run on one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 alu_valid  input  1  ALU result offered.
REQ-006 alu_ready  output  1  ALU result accepted when alu_valid && alu_ready.
REQ-007 alu_rd  input  5  ALU destination register index.
REQ-008 alu_data  input  32  ALU result.
REQ-009 ld_valid  input  1  load response present; always accepted, no ready.
REQ-010 ld_rd  input  5  load destination index.
REQ-011 ld_funct3  input  3  load type (LB/LH/LW/LBU/LHU encoding).
REQ-012 ld_addr_lo  input  2  byte offset of load address.
REQ-013 ld_data  input  32  raw aligned memory word.
REQ-014 wen  output  1  regfile write enable.
REQ-015 rdidx  output  5  regfile write index.
REQ-016 rddata  output  32  regfile write data.
REQ-017 rs1idx, rs2idx  input  5 each  regfile read indices (shared with regfile).
REQ-018 rs1data_rf, rs2data_rf  input  32 each  raw regfile read data.
REQ-019 rs1data, rs2data  output  32 each  read data delivered to execute.
REQ-020 busy  output  1  FIFO non-empty or wen asserted.

Function
REQ-021 wen, rdidx, rddata SHALL be registered; one regfile write per cycle maximum.
REQ-022 Priority per cycle: ld_valid first, else FIFO head, else ALU input accepted this cycle (bypass).
REQ-023 ALU result accepted in cycle N with load idle and FIFO empty SHALL appear on wen/rdidx/rddata in cycle N+1.
REQ-024 An accepted ALU result not written that cycle SHALL be pushed into the FIFO; FIFO pops in order.
REQ-025 alu_ready SHALL equal FIFO not full; simultaneous pop and push when full SHALL NOT be allowed (ready stays low).
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
REQ-027 Load with ld_valid in cycle N SHALL write in cycle N+1, regardless of FIFO occupancy.
REQ-028 Load formatting: LB byte[ld_addr_lo] sign-extended; LBU zero-extended; LH half[ld_addr_lo[1]] sign-extended; LHU zero-extended; LW word unchanged; other funct3 treated as LW.
REQ-029 Writes with destination index 0 (ALU or load) SHALL be consumed but SHALL produce wen=0.
REQ-030 Ordering between a load and an ALU result to the same rd is upstream's responsibility; the block does not reorder within the ALU stream.

Reset
REQ-031 While resetn low: wen=0, rdidx=0, rddata=0, FIFO empty, busy=0, alu_ready=0.
REQ-032 Reset asserted mid-operation SHALL discard FIFO contents and any pending write.
REQ-033 alu_ready SHALL rise in the first cycle after resetn deasserts.

Configuration
REQ-034 Macro CPU4_WB_FWD_EN defined: rs1data = rddata when wen && rdidx==rs1idx && rs1idx!=0, else rs1data_rf; same for rs2.
REQ-035 Macro undefined: rs1data=rs1data_rf and rs2data=rs2data_rf (pure pass-through).

Structure
REQ-036 Shared package cpu4_pkg SHALL hold XLEN=32, REG_IDX_W=5 and load funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101).
REQ-037 Combinational load formatter SHALL be sub-module cpu4_wb_ldfmt; FIFO stays inline.

Verification
REQ-038 ALU rd=3 data=0x11223344, idle load -> next cycle wen=1 rdidx=3 rddata=0x11223344.
REQ-039 ld_valid with ALU valid same cycle (rd=5, rd=6) -> cycle+1 writes x5 load, cycle+2 writes x6 ALU from FIFO.
REQ-040 Loads on 3 consecutive cycles with ALU valid held -> FIFO fills to 2, alu_ready=0, then drains in order once loads stop.
REQ-041 ld_data=0x80FF7F01: LB off 0 -> 0x00000001, LB off 2 -> 0xFFFFFFFF, LBU off 3 -> 0x00000080, LH off 2 -> 0xFFFF80FF, LHU off 0 -> 0x00007F01.
REQ-042 ALU rd=0 data=0xDEADBEEF -> wen stays 0; with CPU4_WB_FWD_EN, write x1=0xAABBCCDD and rs1idx=1 -> rs1data=0xAABBCCDD in the wen cycle.
REQ-043 resetn pulsed low with FIFO holding 2 entries -> wen=0, busy=0 immediately; no stale write after release.
